layer_sequencer: RTL and testbench
==================================

Name: layer_sequencer

Overview:
- Top-level scheduler for the per-layer convolution controllers (L1..L9).
- Launches one layer at a time and waits for that layer's completion, then swaps the ping-pong feature-map BRAM banks.
- Advances the layer index, flags network completion, and guards each layer with a watchdog.
- Sits above the layer controllers; their start/clear inputs and bank-select muxes are driven from here.

Parameters:
- NUM_LAYERS, 9, number of layers sequenced (layer_id runs 0..NUM_LAYERS-1).
- ID_W, 4, width of layer_id; must satisfy 2^ID_W >= NUM_LAYERS.
- WD_W, 16, width of the per-layer watchdog counter; timeout after 2^WD_W-1 RUN cycles.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, request to run the full network; sampled only in IDLE or ERROR.
- layer_done, input, 1, completion from the currently active layer controller (muxed externally by layer_id).
- layer_clr, output, 1, one-cycle clear to the active layer controller's counters.
- layer_start, output, 1, one-cycle launch pulse to the active layer controller.
- layer_id, output, ID_W, index of the active layer.
- bank_sel, output, 1, 0 = read BRAM1/write BRAM2, 1 = read BRAM2/write BRAM1.
- busy, output, 1, high in any state except IDLE and ERROR.
- net_done, output, 1, one-cycle pulse when the last layer finishes.
- err, output, 1, sticky watchdog-timeout flag.

Behaviour:
- Reset (async, any state):
  - state=IDLE, layer_id=0, bank_sel=0, watchdog=0.
  - All outputs 0.
- FSM states: IDLE, CLEAR, LAUNCH, RUN, SWAP, DONE, ERROR. All transitions occur on the rising clk edge.
- IDLE:
  - start=1 -> CLEAR; layer_id<=0, bank_sel<=0.
  - Otherwise stay.
- CLEAR:
  - layer_clr=1 for exactly this cycle.
  - -> LAUNCH.
- LAUNCH:
  - layer_start=1 for exactly this cycle; watchdog<=0.
  - -> RUN.
- RUN:
  - Watchdog increments each cycle.
  - layer_done=1 -> SWAP; this check takes priority over timeout in the same cycle.
  - Else watchdog == 2^WD_W-1 -> ERROR.
- SWAP:
  - bank_sel toggles.
  - If layer_id == NUM_LAYERS-1 -> DONE, and layer_id holds.
  - Else layer_id increments -> CLEAR.
- DONE:
  - net_done=1 for this cycle.
  - -> IDLE; layer_id and bank_sel hold their final values until the next start.
- ERROR:
  - err=1 and stays high.
  - layer_id and bank_sel frozen; busy=0.
  - start=1 -> CLEAR, with err<=0, layer_id<=0, bank_sel<=0.
- Latency:
  - start sampled at edge n: layer_clr high in cycle n+1, layer_start high in n+2, RUN from n+3.
  - layer_done sampled in RUN at edge m: SWAP in m+1; next layer_clr in m+2.
  - Per-layer overhead is 3 cycles: SWAP, CLEAR, LAUNCH.
- Ignored inputs:
  - start in CLEAR/LAUNCH/RUN/SWAP/DONE is ignored; no queuing.
  - layer_done outside RUN is ignored, including a stale high level during CLEAR/LAUNCH.
- Bank sequence:
  - bank_sel during layer k equals k mod 2.
  - After DONE with NUM_LAYERS=9, bank_sel=1, i.e. the final output resides in BRAM2.
- layer_clr and layer_start are never high in the same cycle.
- All outputs are registered or decoded from registered state only; no combinational path from any input to any output.
- Reset asserted mid-RUN: immediate return to IDLE with all outputs 0; the next start begins at layer 0.

Test Plan:
- Reset, then start=1 for 1 cycle -> layer_clr at +1, layer_start at +2, layer_id=0, bank_sel=0, busy=1.
- Full run, layer_done pulsed 10 cycles after each layer_start:
  - layer_id steps 0..8.
  - bank_sel alternates 0,1,0,... across layers.
  - net_done pulses once, with layer_id=8 and bank_sel=1 afterwards.
  - busy=0 after DONE.
- layer_done held high through CLEAR/LAUNCH of layer 3 -> no advance until RUN; SWAP occurs in the first RUN cycle +1.
- WD_W=4 and layer_done withheld -> ERROR after 15 RUN cycles:
  - err=1, busy=0, layer_id frozen.
  - A subsequent start clears err and restarts at layer 0.
- start pulsed during RUN of layer 2 -> ignored; the sequence continues unchanged.
- rst asserted asynchronously mid-layer 5 -> all outputs 0 immediately; the next start launches layer 0 with bank_sel=0.
- layer_done and watchdog terminal count in the same cycle -> SWAP taken, err stays 0.

Source files
------------

// File: rtl/layer_sequencer.sv
// layer_sequencer: top-level scheduler for the per-layer convolution controllers.
// It launches one layer at a time and waits for that layer's layer_done. Between
// layers it swaps the ping-pong feature-map banks and advances layer_id. A
// watchdog guards every layer. Every output comes straight from a flop.
module layer_sequencer #(
  parameter int NUM_LAYERS = 9,
  parameter int ID_W       = 4,
  parameter int WD_W       = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            layer_done,
  output logic            layer_clr,
  output logic            layer_start,
  output logic [ID_W-1:0] layer_id,
  output logic            bank_sel,
  output logic            busy,
  output logic            net_done,
  output logic            err
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_RUN    = 3'd3,
    ST_SWAP   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_LAYERS - 1);
  localparam logic [ID_W-1:0] ID_ONE  = {{(ID_W-1){1'b0}}, 1'b1};
  localparam logic [WD_W-1:0] WD_MAX  = {WD_W{1'b1}};
  localparam logic [WD_W-1:0] WD_ONE  = {{(WD_W-1){1'b0}}, 1'b1};
  localparam logic [WD_W-1:0] WD_ZERO = {WD_W{1'b0}};

  state_t            state_q, state_d;
  logic [ID_W-1:0]   layer_id_q, layer_id_d;
  logic              bank_sel_q, bank_sel_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [WD_W-1:0]   wd_inc_s;
  logic              layer_clr_q, layer_clr_d;
  logic              layer_start_q, layer_start_d;
  logic              busy_q, busy_d;
  logic              net_done_q, net_done_d;
  logic              err_q, err_d;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d    = state_q;
    layer_id_d = layer_id_q;
    bank_sel_d = bank_sel_q;
    wd_d       = wd_q;
    // wd_inc_s counts the RUN cycles of this layer, including the current one.
    wd_inc_s   = wd_q + WD_ONE;

    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (start) begin
          state_d    = ST_CLEAR;
          layer_id_d = {ID_W{1'b0}};
          bank_sel_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_CLEAR: begin
        state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        wd_d    = WD_ZERO;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        wd_d = wd_inc_s;
        // A completion in the same cycle as the terminal count wins.
        if (layer_done) begin
          state_d = ST_SWAP;
        end else if (wd_inc_s == WD_MAX) begin
          state_d = ST_ERROR;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_SWAP: begin
        bank_sel_d = ~bank_sel_q;
        if (layer_id_q == LAST_ID) begin
          state_d = ST_DONE;
        end else begin
          layer_id_d = layer_id_q + ID_ONE;
          state_d    = ST_CLEAR;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs reflect the state being entered, so each pulse lines up with its state cycle.
    layer_clr_d   = (state_d == ST_CLEAR);
    layer_start_d = (state_d == ST_LAUNCH);
    net_done_d    = (state_d == ST_DONE);
    err_d         = (state_d == ST_ERROR);
    busy_d        = (state_d != ST_IDLE) && (state_d != ST_ERROR);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      layer_id_q    <= {ID_W{1'b0}};
      bank_sel_q    <= 1'b0;
      wd_q          <= WD_ZERO;
      layer_clr_q   <= 1'b0;
      layer_start_q <= 1'b0;
      busy_q        <= 1'b0;
      net_done_q    <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      layer_id_q    <= layer_id_d;
      bank_sel_q    <= bank_sel_d;
      wd_q          <= wd_d;
      layer_clr_q   <= layer_clr_d;
      layer_start_q <= layer_start_d;
      busy_q        <= busy_d;
      net_done_q    <= net_done_d;
      err_q         <= err_d;
    end
  end

  assign layer_clr   = layer_clr_q;
  assign layer_start = layer_start_q;
  assign layer_id    = layer_id_q;
  assign bank_sel    = bank_sel_q;
  assign busy        = busy_q;
  assign net_done    = net_done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: a table of per-cycle vectors plus
// hand-written sequences for full runs, watchdog, stale done and async reset.
module tb_layer_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       layer_done = 1'b0;
  logic       layer_clr, layer_start, bank_sel, busy, net_done, err;
  logic [3:0] layer_id;

  int tests = 0;
  int fails = 0;
  int nd_count = 0;

  typedef struct {
    logic       start;
    logic       done;
    logic       clr;
    logic       st;
    logic [3:0] id;
    logic       bank;
    logic       busy;
    logic       nd;
    logic       err;
  } vec_t;

  vec_t vecs[10];

  layer_sequencer #(.NUM_LAYERS(9), .ID_W(4), .WD_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .layer_done(layer_done),
    .layer_clr(layer_clr), .layer_start(layer_start), .layer_id(layer_id),
    .bank_sel(bank_sel), .busy(busy), .net_done(net_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic c, input logic s, input logic [3:0] id,
                         input logic b, input logic bz, input logic nd, input logic e);
    tests++;
    if ({layer_clr, layer_start, layer_id, bank_sel, busy, net_done, err} !== {c, s, id, b, bz, nd, e}) begin
      fails++;
      $display("FAIL %s: got clr=%b st=%b id=%0d bank=%b busy=%b nd=%b err=%b expected clr=%b st=%b id=%0d bank=%b busy=%b nd=%b err=%b",
               name, layer_clr, layer_start, layer_id, bank_sel, busy, net_done, err, c, s, id, b, bz, nd, e);
    end
  endtask

  // Advance one clock; outputs are examined 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (net_done) nd_count++;
  endtask

  task automatic do_reset();
    start = 1'b0;
    layer_done = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    nd_count = 0;
  endtask

  // Wait (bounded) until layer_start is high, then check the layer index and bank.
  task automatic wait_start(input int k);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (layer_start) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL wait_start_L%0d: got no layer_start expected layer_start within 8 cycles", k);
    end else begin
      chk($sformatf("start_id_L%0d", k), 32'(layer_id), 32'(k));
      chk($sformatf("start_bank_L%0d", k), 32'(bank_sel), 32'(k % 2));
    end
  endtask

  // One layer: completion in the 10th cycle after layer_start; returns in SWAP.
  task automatic run_layer(input int k);
    wait_start(k);
    layer_done = 1'b0;
    for (int i = 0; i < 10; i++) step();
    layer_done = 1'b1;
    step();
    layer_done = 1'b0;
  endtask

  initial begin
    // Per-vector: apply inputs, one clock, expected registered outputs.
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0}; // CLEAR L0
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0}; // LAUNCH
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0}; // RUN
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0}; // RUN
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0}; // SWAP
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0}; // CLEAR L1
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0}; // start ignored
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0}; // done in LAUNCH ignored
    vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0}; // SWAP
    vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0}; // CLEAR L2

    do_reset();
    chk_out("reset", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      start = vecs[i].start;
      layer_done = vecs[i].done;
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].clr, vecs[i].st, vecs[i].id, vecs[i].bank,
              vecs[i].busy, vecs[i].nd, vecs[i].err);
    end
    start = 1'b0;
    layer_done = 1'b0;

    // Full nine-layer run.
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 9; k++) run_layer(k);
    chk_out("full_swap8", 1'b0, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("full_done", 1'b0, 1'b0, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    chk_out("full_idle", 1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("net_done_count", 32'(nd_count), 32'd1);

    // Stale layer_done held through CLEAR/LAUNCH of layer 3.
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) run_layer(k);
    layer_done = 1'b1;
    step();
    chk_out("stale_clear3", 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("stale_launch3", 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("stale_run3", 1'b0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("stale_swap3", 1'b0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    layer_done = 1'b0;
    step();
    chk_out("stale_clear4", 1'b1, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0);

    // start pulsed during RUN of layer 2 is ignored.
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 2; k++) run_layer(k);
    wait_start(2);
    step();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk_out("start_in_run", 1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("start_in_run2", 1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    layer_done = 1'b1;
    step();
    layer_done = 1'b0;
    step();
    chk_out("after_ignored_start", 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);

    // Watchdog timeout in layer 2 (WD_W=4: 15 RUN cycles).
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 2; k++) run_layer(k);
    wait_start(2);
    for (int i = 0; i < 15; i++) step();
    chk_out("wd_run15", 1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("wd_error", 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    layer_done = 1'b1;
    step();
    step();
    layer_done = 1'b0;
    chk_out("wd_error_sticky", 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_out("wd_restart", 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("wd_restart_launch", 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Completion exactly at the watchdog terminal count.
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_start(0);
    for (int i = 0; i < 15; i++) step();
    layer_done = 1'b1;
    step();
    layer_done = 1'b0;
    chk_out("tc_swap", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("tc_clear1", 1'b1, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of layer 5.
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) run_layer(k);
    wait_start(5);
    step();
    step();
    chk_out("pre_rst_l5", 1'b0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk_out("post_rst_clear", 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("post_rst_launch", 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
